execute_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle. It takes its operands after forwarding resolution (clean rs1/rs2 data) and holds the pipeline through a valid/ready handshake until the result can be handed back. It is parametrised in datapath width and sits beside the single-cycle ALU; the ALU's result mux selects it for OP-opcode instructions with funct7 = 0000001.

---
 rtl/execute_muldiv_if.sv | 31 +++
 rtl/execute_muldiv.sv | 200 ++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: request/response bundle for the iterative RV32M unit.
//   master : execute-stage side (drives the request, flush and out_ready)
//   slave  : execute_muldiv itself
//   in_valid/in_ready      request handshake, funct3/rs1d/rs2d operands
//   flush                  kill in-flight or pending op
//   out_valid/out_ready    result handshake, result held while out_valid
//   busy                   unit not idle
interface execute_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1d;
  logic [WIDTH-1:0] rs2d;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, funct3, rs1d, rs2d, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, rs1d, rs2d, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M multiply/divide, one bit per cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    execute_muldiv_if.slave (request, flush, result handshake, busy)
// Multiply is shift-add on a 2*WIDTH product register; divide is restoring
// division sharing the same register ({remainder, quotient}). Operands are
// reduced to magnitudes at accept and the sign is re-applied on the last step.
// Optional: define EXECUTE_MULDIV_EARLY_OUT_EN to resolve divide-by-zero,
// signed overflow and zero-operand multiplies at accept (done one edge later).
module execute_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  execute_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opd;
  logic [WIDTH-1:0]   r_result;
  logic               r_neg;
  logic               r_div0;
  logic               r_ovf;
  logic [CW-1:0]      r_count;

  // Request decode
  logic             w_accept;
  logic             w_is_div;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg_in;
  logic             w_div0;
  logic             w_ovf;

  assign w_accept = (r_state == IDLE) & bus.in_valid & ~bus.flush;
  assign w_is_div = bus.funct3[2];
  assign w_sgn_a  = w_is_div ? ~bus.funct3[0]
                             : ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b010));
  assign w_sgn_b  = w_is_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001);
  assign w_a_neg  = w_sgn_a & bus.rs1d[WIDTH-1];
  assign w_b_neg  = w_sgn_b & bus.rs2d[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-bus.rs1d) : bus.rs1d;
  assign w_b_mag  = w_b_neg ? (-bus.rs2d) : bus.rs2d;
  // Remainder follows the dividend sign; everything else is the xor of signs.
  assign w_neg_in = (w_is_div & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0   = w_is_div & (bus.rs2d == '0);
  assign w_ovf    = w_is_div & ~bus.funct3[0] & (bus.rs1d == SMIN) & (bus.rs2d == '1);

`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
  logic             r_fast;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_res;

  assign w_fast = w_div0 | w_ovf |
                  (~w_is_div & ((bus.rs1d == '0) | (bus.rs2d == '0)));

  always_comb begin
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = bus.funct3[1] ? bus.rs1d : '1;
    end else if (w_ovf) begin
      w_fast_res = bus.funct3[1] ? '0 : SMIN;
    end
  end
`endif

  // One iteration step
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_mul_hi;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_last;
  logic               w_step;

  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
  assign w_mul_hi   = r_prod[0] ? w_mul_sum : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
  assign w_mul_next = {w_mul_hi, r_prod[WIDTH-1:1]};

  // Remainder stays below the divisor, so a borrow in bit WIDTH means restore.
  assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opd};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};

  assign w_prod_next = r_op[2] ? w_div_next : w_mul_next;
  assign w_last      = (r_count == CW'(WIDTH - 1));

`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
  assign w_step = (r_state == CALC) & ~bus.flush & ~r_fast;
`else
  assign w_step = (r_state == CALC) & ~bus.flush;
`endif

  // Sign fix-up and special cases applied to the final step's value
  logic [2*WIDTH-1:0] w_full_fix;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [WIDTH-1:0]   w_final;

  always_comb begin
    w_full_fix = r_neg ? (-w_prod_next) : w_prod_next;
    w_q_fix    = r_neg ? (-w_prod_next[WIDTH-1:0]) : w_prod_next[WIDTH-1:0];
    w_r_fix    = r_neg ? (-w_prod_next[2*WIDTH-1:WIDTH]) : w_prod_next[2*WIDTH-1:WIDTH];
    w_final    = '0;
    case (r_op)
      3'b000:                 w_final = w_full_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_full_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_final = r_div0 ? '1 : (r_ovf ? SMIN : w_q_fix);
      // Divide-by-zero remainder is |rs1d| re-signed, i.e. rs1d itself.
      default:                w_final = r_ovf ? '0 : w_r_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = CALC;
      CALC: begin
        if (w_last) w_state_next = DONE;
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
        if (r_fast) w_state_next = DONE;
`endif
      end
      DONE: if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (bus.flush) w_state_next = IDLE;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_prod   <= '0;
      r_opd    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_count  <= '0;
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
      r_fast   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op    <= bus.funct3;
      r_opd   <= w_is_div ? w_b_mag : w_a_mag;
      r_prod  <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      r_neg   <= w_neg_in;
      r_div0  <= w_div0;
      r_ovf   <= w_ovf;
      r_count <= '0;
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
      // Fast result parks in the product register so a flush can still drop it.
      r_fast  <= w_fast;
      if (w_fast) r_prod <= {{WIDTH{1'b0}}, w_fast_res};
`endif
    end else if (w_step) begin
      r_prod  <= w_prod_next;
      r_count <= r_count + 1'b1;
      if (w_last) r_result <= w_final;
    end
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
    else if ((r_state == CALC) && r_fast && !bus.flush) begin
      r_result <= r_prod[WIDTH-1:0];
    end
`endif
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.result    = r_result;

endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp = '0;

  execute_muldiv_if #(.WIDTH(W)) bus ();

  execute_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference using native 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb_;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    p   = '0;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 32'd0) || (b == 32'd0);
  endfunction
`endif

  // Present one request; returns just after the accepting edge.
  task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.rs1d     = a;
    bus.rs2d     = b;
    tick();
    bus.in_valid = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.rs1d     = $urandom;
    bus.rs2d     = $urandom;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  // Wait (bounded) for out_valid, check latency and scoreboard head.
  task automatic finish_op(input string tag, input int exp_lat, input bit release_now);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    last_exp = sb.pop_front();
    check(tag, bus.result, last_exp);
    if (release_now) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int lat = W;
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
    if (is_fast(f3, a, b)) lat = 1;
`endif
    sb.push_back(exp);
    start(f3, a, b);
    finish_op(tag, lat, 1'b1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;

    bus.in_valid  = 1'b0;
    bus.funct3    = '0;
    bus.rs1d      = '0;
    bus.rs2d      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_busy",      {31'd0, bus.busy},      32'd0);
    check("reset_result",    bus.result,             32'd0);
    rst_n = 1'b1;
    tick();

    run("mul_7_x_m3",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh_min_sq",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu_ones",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu_ones",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run("divu_ones_16",  3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);
    run("div_overflow",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_overflow",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run("divu_by_zero",  3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    run("remu_by_zero",  3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    run("div_by_zero",   3'd4, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF);
    run("rem_neg_by_0",  3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB);
    run("mulh_zero",     3'd1, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0000);

    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) b = b >> 20;
      run("random_op", f3, a, b, ref_op(f3, a, b));
    end

    // Back-pressure: result and in_ready frozen while out_ready is low.
    sb.push_back(32'h0000_0004);
    start(3'd5, 32'd100, 32'd23);
    finish_op("divu_backpressure", W, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_result",    bus.result,             last_exp);
      check("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.push_back(32'hFFFF_FFF9);
    start(3'd0, 32'hFFFF_FFFF, 32'd7);
    finish_op("b2b_mul", W, 1'b1);

    // Flush with a pending request in IDLE accepts nothing.
    bus.in_valid = 1'b1;
    bus.funct3   = 3'd4;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("idle_flush_busy", {31'd0, bus.busy}, 32'd0);

    // Flush at CALC step 15.
    start(3'd4, 32'd1000, 32'd7);
    repeat (15) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_busy",      {31'd0, bus.busy},      32'd0);
    check("flush_result",    bus.result,             last_exp);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("flush_no_out_valid", {31'd0, seen}, 32'd0);

    // Asynchronous reset at CALC step 20, checked between clock edges.
    start(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (20) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_busy",      {31'd0, bus.busy},      32'd0);
    check("async_rst_result",    bus.result,             32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run("after_reset_rem", 3'd6, 32'd17, 32'hFFFF_FFFB, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
